// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Three-cycle-per-instruction control sequencer for an external ALU and
//   register file. Each instruction goes FETCH -> EXEC -> WB. The instruction
//   word is read combinationally from a ROM addressed by pc. The ALU opcode is
//   presented during EXEC. The ALU flag is captured in WB.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous active-high reset (priority over start)
//   start    in   1   begin execution at pc 0 (only from IDLE or HALTED)
//   instr    in   9   instruction word at address pc
//   alu_flag in   1   ALU overflow/compare result, valid during WB
//   pc       out  8   instruction address
//   alu_op   out  6   ir[8:3] during EXEC, zero otherwise
//   rd_sel   out  3   register operand ir[2:0]
//   rf_we    out  1   register-file write strobe (one WB cycle)
//   flag     out  1   architectural flag register
//   busy     out  1   high in FETCH, EXEC, WB
//   done     out  1   high in HALTED
//   err      out  1   illegal-opcode trap indicator
//   retired  out  16  retired-instruction counter, saturating
//
// Configuration macro
//   ALU_SEQ_ILLEGAL_TRAP_EN : when defined, op 000/001 halts with err=1.
//                             When undefined, they execute as NOP and err=0.
// -----------------------------------------------------------------------------
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  instr,
    input  logic        alu_flag,
    output logic [7:0]  pc,
    output logic [5:0]  alu_op,
    output logic [2:0]  rd_sel,
    output logic        rf_we,
    output logic        flag,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [8:0]  r_ir;
    logic [5:0]  r_alu_op;
    logic        r_rf_we;
    logic        r_flag;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_retired;

    // Decode of the latched instruction
    logic [2:0]  w_op;
    logic [2:0]  w_func;
    logic        w_is_write;
    logic        w_is_flagw;
    logic        w_is_halt;
    logic        w_br_taken;
    logic [7:0]  w_br_target;
    logic [7:0]  w_pc_inc;
    logic        w_stop;

    assign w_op   = r_ir[8:6];
    assign w_func = r_ir[5:3];

    // ADD, DIST, and A-type LSL/LSR/INCR/ZERO produce a register result
    assign w_is_write = (w_op == 3'b010) || (w_op == 3'b101) ||
                        ((w_op == 3'b110) &&
                         ((w_func == 3'b000) || (w_func == 3'b001) ||
                          (w_func == 3'b010) || (w_func == 3'b101)));

    // ADD, MATCH, LT, and A-type LSL/AND1/EQZ update the flag
    assign w_is_flagw = (w_op == 3'b010) || (w_op == 3'b011) || (w_op == 3'b100) ||
                        ((w_op == 3'b110) &&
                         ((w_func == 3'b000) || (w_func == 3'b011) || (w_func == 3'b100)));

    assign w_is_halt = (w_op == 3'b110) && (w_func == 3'b111);

    // BNO branches on flag==0, BOF on flag==1. Both test the flag value held
    // before this WB, which is safe because neither op writes the flag.
    assign w_br_taken = (w_op == 3'b111) &&
                        (((w_func == 3'b000) && !r_flag) ||
                         ((w_func == 3'b001) &&  r_flag));

    // 8-bit add wraps modulo 256 naturally
    assign w_br_target = r_pc + {{5{r_ir[2]}}, r_ir[2:0]};
    assign w_pc_inc    = r_pc + 8'd1;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic r_err;
    logic w_is_illegal;
    assign w_is_illegal = (w_op == 3'b000) || (w_op == 3'b001);
    assign w_stop       = w_is_halt || w_is_illegal;
    assign err          = r_err;
`else
    assign w_stop       = w_is_halt;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= 8'd0;
            r_ir      <= 9'd0;
            r_alu_op  <= 6'd0;
            r_rf_we   <= 1'b0;
            r_flag    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_retired <= 16'd0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    // Restart leaves the flag register alone
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_pc      <= 8'd0;
                        r_retired <= 16'd0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                        r_err     <= 1'b0;
`endif
                    end
                end

                S_FETCH: begin
                    // Opcode register is loaded alongside ir so alu_op is
                    // valid for the whole EXEC cycle straight from a flop
                    r_ir     <= instr;
                    r_alu_op <= instr[8:3];
                    r_state  <= S_EXEC;
                end

                S_EXEC: begin
                    r_alu_op <= 6'd0;
                    r_rf_we  <= w_is_write;
                    r_state  <= S_WB;
                end

                S_WB: begin
                    r_rf_we <= 1'b0;
                    if (r_retired != 16'hFFFF) begin
                        r_retired <= r_retired + 16'd1;
                    end
                    if (w_is_flagw) begin
                        r_flag <= alu_flag;
                    end
                    if (w_stop) begin
                        r_state <= S_HALTED;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                        r_err   <= w_is_illegal;
`endif
                    end else begin
                        r_state <= S_FETCH;
                        r_pc    <= w_br_taken ? w_br_target : w_pc_inc;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign pc      = r_pc;
    assign alu_op  = r_alu_op;
    assign rd_sel  = r_ir[2:0];
    assign rf_we   = r_rf_we;
    assign flag    = r_flag;
    assign busy    = r_busy;
    assign done    = r_done;
    assign retired = r_retired;

endmodule
